// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default line timing,
// shared with the transmit side.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned DEFAULT_CLOCKS_PER_PULSE = 2604;  // 50 MHz / 19200 baud
  localparam int unsigned DEFAULT_BITS_PER_WORD    = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous UART line; resets to the idle
// (high) level so reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_packer.sv
// UART receiver packing NUM_WORDS words (first word in the LSBs) into one
// valid/ready beat. Define UART_RX_PARITY_EN for even-parity frames.
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE,
  parameter int unsigned BITS_PER_WORD    = DEFAULT_BITS_PER_WORD,
  parameter int unsigned NUM_WORDS        = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               rx,
  output logic [NUM_WORDS*BITS_PER_WORD-1:0] m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic                               err_frame,
  output logic                               err_parity,
  output logic                               err_overflow,
  output logic                               busy
);

  localparam int unsigned BCW = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BTW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int unsigned WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BTW-1:0] BIT_LAST  = BTW'(BITS_PER_WORD - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(NUM_WORDS - 1);

  rx_state_t                          state;
  logic                               rx_s;
  logic [BCW-1:0]                     baud_cnt;
  logic [BTW-1:0]                     bit_cnt;
  logic [WCW-1:0]                     word_cnt;
  logic [BITS_PER_WORD-1:0]           shreg;
  logic [NUM_WORDS*BITS_PER_WORD-1:0] pack;
  logic [NUM_WORDS*BITS_PER_WORD-1:0] pack_next;
  logic                               break_wait;
  logic                               word_ok;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bad;
  assign word_ok = !parity_bad;
`else
  assign word_ok    = 1'b1;
  assign err_parity = 1'b0;
`endif

  // Pack register with the just-received word dropped into its slot; this
  // is what a completing beat presents on m_data.
  always_comb begin
    pack_next = pack;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (word_cnt == WCW'(k)) pack_next[k*BITS_PER_WORD +: BITS_PER_WORD] = shreg;
    end
  end

  assign busy = (state != IDLE) || (word_cnt != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      shreg        <= '0;
      pack         <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      err_frame    <= 1'b0;
      err_overflow <= 1'b0;
      break_wait   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      err_parity   <= 1'b0;
      parity_bad   <= 1'b0;
`endif
    end else begin
      err_frame    <= 1'b0;
      err_overflow <= 1'b0;
`ifdef UART_RX_PARITY_EN
      err_parity   <= 1'b0;
`endif
      // A beat loaded later in this block overrides this clear.
      if (m_valid && m_ready) m_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end

        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[BITS_PER_WORD-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= STOP;
            if ((^shreg) != rx_s) begin
              err_parity <= 1'b1;
              parity_bad <= 1'b1;
              word_cnt   <= '0;
            end else begin
              parity_bad <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (break_wait) begin
            if (rx_s) begin
              break_wait <= 1'b0;
              state      <= IDLE;
            end
          end else if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (!rx_s) begin
              err_frame  <= 1'b1;
              word_cnt   <= '0;
              break_wait <= 1'b1;
            end else begin
              state <= IDLE;
              if (word_ok) begin
                pack <= pack_next;
                if (word_cnt == WORD_LAST) begin
                  word_cnt <= '0;
                  if (!m_valid || m_ready) begin
                    m_data  <= pack_next;
                    m_valid <= 1'b1;
                  end else begin
                    err_overflow <= 1'b1;
                  end
                end else begin
                  word_cnt <= word_cnt + 1'b1;
                end
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
